// File: rtl/pb_event_arbiter.sv
// Push-button front end: per-button sync/debounce/press detect, arbitration into a small event FIFO.
// Define PB_ARB_ROUND_ROBIN_EN for round-robin grant order; otherwise the lowest pending index wins.

module pb_lane (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    input  logic tick,
    input  logic grant,
    output logic pend,
    output logic drop
);
    logic [1:0] sync;
    logic       sample, deb, deb_q, rise;

    assign rise = deb & ~deb_q;
    // a new press while the previous one is still waiting (and not leaving now) is lost
    assign drop = rise & pend & ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            sample <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            pend   <= 1'b0;
        end else begin
            sync  <= {sync[0], pb};
            deb_q <= deb;
            if (tick) begin
                sample <= sync[1];
                if (sync[1] == sample) deb <= sample;
            end
            pend <= (pend & ~grant) | rise;
        end
    end
endmodule

module pb_event_arbiter #(
    parameter int NUM_PB          = 10,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_PB-1:0] pb,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [3:0]        evt_code,
    input  logic              ovf_clr,
    output logic              ovf,
    output logic [NUM_PB-1:0] pending
);
    localparam int PW = $clog2(DEBOUNCE_CYCLES);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PLAST = PW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]   FULL  = (AW+1)'(FIFO_DEPTH);

    logic [PW-1:0]              presc;
    logic                       tick;
    logic [NUM_PB-1:0]          grant, drop, rot;
    logic                       gnt_vld, push_ok, pop;
    logic [3:0]                 gnt_idx;
    logic [FIFO_DEPTH-1:0][3:0] mem;
    logic [AW-1:0]              wptr, rptr;
    logic [AW:0]                count;
`ifdef PB_ARB_ROUND_ROBIN_EN
    logic [3:0]                 rr_ptr;
`endif

    assign tick = (presc == PLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       presc <= '0;
        else if (tick) presc <= '0;
        else           presc <= presc + 1'b1;
    end

    for (genvar i = 0; i < NUM_PB; i++) begin : g_lane
        pb_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .pb    (pb[i]),
            .tick  (tick),
            .grant (grant[i]),
            .pend  (pending[i]),
            .drop  (drop[i])
        );
    end

    assign pop     = evt_valid & evt_ready;
    assign push_ok = (count < FULL) | pop;

    // scan downward so the lowest (rotated) position is the one that sticks
    always_comb begin
`ifdef PB_ARB_ROUND_ROBIN_EN
        rot = NUM_PB'({pending, pending} >> rr_ptr);
`else
        rot = pending;
`endif
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_PB - 1; k >= 0; k--) begin
            if (push_ok && rot[k]) begin
                gnt_vld = 1'b1;
`ifdef PB_ARB_ROUND_ROBIN_EN
                gnt_idx = 4'((int'(rr_ptr) + k) % NUM_PB);
`else
                gnt_idx = 4'(k);
`endif
            end
        end
        grant = gnt_vld ? (NUM_PB'(1) << gnt_idx) : '0;
    end

`ifdef PB_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr_ptr <= '0;
        else if (gnt_vld) rr_ptr <= 4'((int'(gnt_idx) + 1) % NUM_PB);
    end
`endif

    always_ff @(posedge clk) begin
        if (gnt_vld) mem[wptr] <= gnt_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (gnt_vld) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({gnt_vld, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? mem[rptr] : 4'd0;

    // set beats clear when both land in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          ovf <= 1'b0;
        else if (|drop)   ovf <= 1'b1;
        else if (ovf_clr) ovf <= 1'b0;
    end
endmodule
